// File: rtl/bht_btb_update_pipe_pkg.sv
// Shared definitions for the BHT/BTB update pipeline: FSM encodings,
// entry-word field layout helpers and counter reset values.
package bht_btb_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Low-order mask of the given width (capped at the 64-bit work width)
    function automatic logic [63:0] field_mask(input int width);
        if (width >= 64) begin
            return {64{1'b1}};
        end else begin
            return (64'd1 << width) - 64'd1;
        end
    endfunction

    function automatic int tag_lsb(input int tgt_w);
        return tgt_w;
    endfunction

    function automatic int vld_bit(input int tgt_w, input int tag_w);
        return tgt_w + tag_w;
    endfunction

    function automatic int cnt_lsb(input int tgt_w, input int tag_w);
        return tgt_w + tag_w + 1;
    endfunction

    // Weakly-taken counter value: 2^(CNT_W-1)
    function automatic logic [63:0] cnt_weak_t(input int cnt_w);
        return 64'd1 << (cnt_w - 1);
    endfunction

    // Weakly-not-taken counter value: 2^(CNT_W-1)-1
    function automatic logic [63:0] cnt_weak_nt(input int cnt_w);
        return (64'd1 << (cnt_w - 1)) - 64'd1;
    endfunction

    // Extract one field from an entry word held in 64-bit form
    function automatic logic [63:0] entry_field(input logic [63:0] word, input int lsb, input int width);
        return (word >> lsb) & field_mask(width);
    endfunction

    // Assemble an entry word: target | tag | valid | counter, upper bits zero
    function automatic logic [63:0] entry_pack(input int tgt_w, input int tag_w, input int cnt_w,
                                               input logic [63:0] tgt, input logic [63:0] tag,
                                               input logic vld, input logic [63:0] cnt);
        logic [63:0] w;
        w = tgt & field_mask(tgt_w);
        w = w | ((tag & field_mask(tag_w)) << tag_lsb(tgt_w));
        w = w | (64'(vld) << vld_bit(tgt_w, tag_w));
        w = w | ((cnt & field_mask(cnt_w)) << cnt_lsb(tgt_w, tag_w));
        return w;
    endfunction

endpackage

// File: rtl/bht_btb_update_pipe_if.sv
// Update request channel from execute plus the entry-RAM port.
interface bht_btb_update_pipe_if #(
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 5,
    parameter int TGT_W  = 11,
    parameter int DATA_W = 32
);
    import bht_btb_pkg::*;

    logic              upd_valid;
    logic              upd_ready;
    logic [IDX_W-1:0]  upd_index;
    logic [TAG_W-1:0]  upd_tag;
    logic [TGT_W-1:0]  upd_target;
    logic              upd_is_branch;
    logic              upd_taken;
    logic [IDX_W-1:0]  mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [IDX_W-1:0]  mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;

    modport master (
        output upd_valid, upd_index, upd_tag, upd_target, upd_is_branch, upd_taken,
        input  upd_ready,
        input  mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output mem_rd_data
    );

    modport slave (
        input  upd_valid, upd_index, upd_tag, upd_target, upd_is_branch, upd_taken,
        output upd_ready,
        output mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mem_rd_data
    );
endinterface

// File: rtl/bht_btb_update_pipe_entry_update.sv
// Stage-B entry update: tag hit/allocate and saturating counter step.
module bht_btb_entry_update
    import bht_btb_pkg::*;
#(
    parameter int TAG_W  = 5,
    parameter int TGT_W  = 11,
    parameter int CNT_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] entry_i,
    input  logic [TAG_W-1:0]  upd_tag_i,
    input  logic [TGT_W-1:0]  upd_tgt_i,
    input  logic              upd_taken_i,
    output logic [DATA_W-1:0] entry_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};

    logic [TGT_W-1:0] cur_tgt_s, new_tgt_s;
    logic [TAG_W-1:0] cur_tag_s, new_tag_s;
    logic [CNT_W-1:0] cur_cnt_s, new_cnt_s;
    logic             cur_vld_s, new_vld_s, hit_s;

    // Unpack the current entry and form the updated one
    always_comb begin
        cur_tgt_s = TGT_W'(entry_field(64'(entry_i), 0, TGT_W));
        cur_tag_s = TAG_W'(entry_field(64'(entry_i), tag_lsb(TGT_W), TAG_W));
        cur_vld_s = 1'(entry_field(64'(entry_i), vld_bit(TGT_W, TAG_W), 1));
        cur_cnt_s = CNT_W'(entry_field(64'(entry_i), cnt_lsb(TGT_W, TAG_W), CNT_W));
        hit_s     = cur_vld_s && (cur_tag_s == upd_tag_i);

        new_tgt_s = cur_tgt_s;
        new_tag_s = cur_tag_s;
        new_vld_s = cur_vld_s;
        new_cnt_s = cur_cnt_s;

        if (!hit_s) begin
            // Allocate: fresh entry starts at the weak state matching the outcome
            new_tgt_s = upd_tgt_i;
            new_tag_s = upd_tag_i;
            new_vld_s = 1'b1;
            new_cnt_s = upd_taken_i ? CNT_W'(cnt_weak_t(CNT_W)) : CNT_W'(cnt_weak_nt(CNT_W));
        end else if (upd_taken_i) begin
            new_tgt_s = upd_tgt_i;
            new_cnt_s = (cur_cnt_s == CNT_MAX) ? CNT_MAX : cur_cnt_s + CNT_W'(1);
        end else begin
            new_cnt_s = (cur_cnt_s == CNT_MIN) ? CNT_MIN : cur_cnt_s - CNT_W'(1);
        end

        entry_o = DATA_W'(entry_pack(TGT_W, TAG_W, CNT_W, 64'(new_tgt_s), 64'(new_tag_s),
                                     new_vld_s, 64'(new_cnt_s)));
    end
endmodule

// File: rtl/bht_btb_update_pipe.sv
// Pipelined read-modify-write updater for the combined BHT/BTB entry RAM.
// Clears the table after reset, then takes one update per cycle.
module bht_btb_update_pipe
    import bht_btb_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int TAG_W  = 5,
    parameter int TGT_W  = 11,
    parameter int CNT_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    bht_btb_update_pipe_if.slave   bus,
    output logic                   init_done
);
    if ((TGT_W + TAG_W + 1 + CNT_W > DATA_W) || (DATA_W > 64) || (CNT_W < 2)) begin : g_bad_cfg
        $error("bht_btb_update_pipe: entry fields do not fit the RAM word");
    end

    logic [0:0]        state_q, state_d;
    logic [IDX_W:0]    init_idx_q, init_idx_d;
    logic              init_done_q, init_done_d;
    // Stage B: captured request
    logic              b_valid_q, b_valid_d, b_br_q, b_br_d, b_taken_q, b_taken_d;
    logic [IDX_W-1:0]  b_idx_q, b_idx_d;
    logic [TAG_W-1:0]  b_tag_q, b_tag_d;
    logic [TGT_W-1:0]  b_tgt_q, b_tgt_d;
    // Stage C: RAM write port registers double as the C index/data
    logic              c_valid_q, c_valid_d, c_wr_q, c_wr_d;
    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    // Stage D: last write, still invisible to a read issued on its write cycle
    logic              d_valid_q, d_valid_d, d_wr_q, d_wr_d;
    logic [IDX_W-1:0]  d_idx_q, d_idx_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;

    logic              accept_s;
    logic [DATA_W-1:0] fwd_entry_s, new_entry_s;

    assign bus.upd_ready   = init_done_q;
    assign bus.mem_rd_addr = bus.upd_index;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign init_done       = init_done_q;
    assign accept_s        = bus.upd_valid & init_done_q;

    // Stage-B entry source: newest in-flight write to the same index wins over RAM
    always_comb begin
        if (c_valid_q && c_wr_q && (wr_addr_q == b_idx_q)) begin
            fwd_entry_s = wr_data_q;
        end else if (d_valid_q && d_wr_q && (d_idx_q == b_idx_q)) begin
            fwd_entry_s = d_data_q;
        end else begin
            fwd_entry_s = bus.mem_rd_data;
        end
    end

    bht_btb_entry_update #(
        .TAG_W (TAG_W),
        .TGT_W (TGT_W),
        .CNT_W (CNT_W),
        .DATA_W(DATA_W)
    ) u_entry_update (
        .entry_i    (fwd_entry_s),
        .upd_tag_i  (b_tag_q),
        .upd_tgt_i  (b_tgt_q),
        .upd_taken_i(b_taken_q),
        .entry_o    (new_entry_s)
    );

    // Init sweep FSM and B->C->D pipeline advance
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        b_valid_d   = 1'b0;
        b_idx_d     = bus.upd_index;
        b_tag_d     = bus.upd_tag;
        b_tgt_d     = bus.upd_target;
        b_br_d      = bus.upd_is_branch;
        b_taken_d   = bus.upd_taken;
        c_valid_d   = 1'b0;
        c_wr_d      = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        d_valid_d   = 1'b0;
        d_wr_d      = 1'b0;
        d_idx_d     = d_idx_q;
        d_data_d    = d_data_q;

        case (state_q)
            ST_INIT: begin
                if (init_idx_q == (IDX_W+1)'(DEPTH)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = init_idx_q[IDX_W-1:0];
                    wr_data_d  = {DATA_W{1'b0}};
                    init_idx_d = init_idx_q + (IDX_W+1)'(1);
                end
            end
            ST_RUN: begin
                b_valid_d = accept_s;
                c_valid_d = b_valid_q;
                c_wr_d    = b_valid_q & b_br_q;
                wr_en_d   = b_valid_q & b_br_q;
                if (b_valid_q && b_br_q) begin
                    wr_addr_d = b_idx_q;
                    wr_data_d = new_entry_s;
                end else begin
                    wr_addr_d = wr_addr_q;
                    wr_data_d = wr_data_q;
                end
                d_valid_d = c_valid_q;
                d_wr_d    = c_wr_q;
                d_idx_d   = wr_addr_q;
                d_data_d  = wr_data_q;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and pipeline registers; reset drops in-flight work and restarts the sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_idx_q  <= {(IDX_W+1){1'b0}};
            init_done_q <= 1'b0;
            b_valid_q   <= 1'b0;
            b_idx_q     <= {IDX_W{1'b0}};
            b_tag_q     <= {TAG_W{1'b0}};
            b_tgt_q     <= {TGT_W{1'b0}};
            b_br_q      <= 1'b0;
            b_taken_q   <= 1'b0;
            c_valid_q   <= 1'b0;
            c_wr_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {IDX_W{1'b0}};
            wr_data_q   <= {DATA_W{1'b0}};
            d_valid_q   <= 1'b0;
            d_wr_q      <= 1'b0;
            d_idx_q     <= {IDX_W{1'b0}};
            d_data_q    <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            b_valid_q   <= b_valid_d;
            b_idx_q     <= b_idx_d;
            b_tag_q     <= b_tag_d;
            b_tgt_q     <= b_tgt_d;
            b_br_q      <= b_br_d;
            b_taken_q   <= b_taken_d;
            c_valid_q   <= c_valid_d;
            c_wr_q      <= c_wr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            d_valid_q   <= d_valid_d;
            d_wr_q      <= d_wr_d;
            d_idx_q     <= d_idx_d;
            d_data_q    <= d_data_d;
        end
    end
endmodule

// File: tb/tb_bht_btb_update_pipe.sv
// Randomized bench for bht_btb_update_pipe with a per-entry reference table
// and an expected-write scoreboard.
module tb_bht_btb_update_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_done;

    bht_btb_update_pipe_if #(.IDX_W(6), .TAG_W(5), .TGT_W(11), .DATA_W(32)) bus ();

    bht_btb_update_pipe #(
        .DEPTH(64), .IDX_W(6), .TAG_W(5), .TGT_W(11), .CNT_W(2), .DATA_W(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Environment RAM: sync read, old data on read-during-write
    logic [31:0] ram [64];
    always @(posedge clk) begin
        bus.mem_rd_data <= ram[bus.mem_rd_addr];
        if (bus.mem_wr_en) ram[bus.mem_wr_addr] <= bus.mem_wr_data;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference table: what each entry should hold after all accepted updates so far
    int m_tag [64];
    int m_tgt [64];
    int m_cnt [64];
    bit m_vld [64];

    typedef struct {
        int          at;
        int          idx;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_word(int tgt, int tag, int vld, int cnt);
        return 32'(tgt) + (32'(tag) * 32'd2048) + (32'(vld) * 32'd65536) + (32'(cnt) * 32'd131072);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) begin
            m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0; m_vld[i] = 1'b0;
        end
    endfunction

    // Apply one accepted update to the reference table and schedule its write
    function automatic void model_update(int idx, int tag, int tgt, bit br, bit tk, int now);
        exp_t e;
        if (!br) return;
        if (m_vld[idx] && m_tag[idx] == tag) begin
            if (tk) begin
                m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
                m_tgt[idx] = tgt;
            end else begin
                m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
            end
        end else begin
            m_vld[idx] = 1'b1;
            m_tag[idx] = tag;
            m_tgt[idx] = tgt;
            m_cnt[idx] = tk ? 2 : 1;
        end
        e.at = now + 2;
        e.idx = idx;
        e.data = mk_word(m_tgt[idx], m_tag[idx], 1, m_cnt[idx]);
        exp_q.push_back(e);
    endfunction

    // Write-port monitor: every RUN cycle must match the schedule exactly
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                check_eq("wr_en", 64'(bus.mem_wr_en), 64'd1);
                check_eq("wr_addr", 64'(bus.mem_wr_addr), 64'(exp_q[0].idx));
                check_eq("wr_data", 64'(bus.mem_wr_data), 64'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                check_eq("wr_idle", 64'(bus.mem_wr_en), 64'd0);
            end
        end
    end

    task automatic drive(input bit v, input int idx, input int tag, input int tgt, input bit br, input bit tk);
        @(negedge clk);
        bus.upd_valid     = v;
        bus.upd_index     = 6'(idx);
        bus.upd_tag       = 5'(tag);
        bus.upd_target    = 11'(tgt);
        bus.upd_is_branch = br;
        bus.upd_taken     = tk;
        if (v && bus.upd_ready) model_update(idx, tag, tgt, br, tk, cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Reset, check reset outputs, then watch the 64-entry clearing sweep
    task automatic init_check();
        int nw;
        int bad;
        int early;
        nw = 0; bad = 0; early = 0;
        @(negedge clk);
        reset = 1'b1;
        bus.upd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_init_done", 64'(init_done), 64'd0);
        check_eq("rst_ready", 64'(bus.upd_ready), 64'd0);
        check_eq("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
        check_eq("rst_wr_addr", 64'(bus.mem_wr_addr), 64'd0);
        check_eq("rst_wr_data", 64'(bus.mem_wr_data), 64'd0);
        reset = 1'b0;
        for (int e = 1; e <= 64; e++) begin
            @(posedge clk);
            #1;
            if (bus.mem_wr_en) nw++;
            if (!bus.mem_wr_en || bus.mem_wr_addr != 6'(e - 1) || bus.mem_wr_data != 32'd0) bad++;
            if (init_done || bus.upd_ready) early++;
        end
        @(posedge clk);
        #1;
        check_eq("init_writes", 64'(nw), 64'd64);
        check_eq("init_bad_writes", 64'(bad), 64'd0);
        check_eq("init_early_done", 64'(early), 64'd0);
        check_eq("init_done_c65", 64'(init_done), 64'd1);
        check_eq("ready_c65", 64'(bus.upd_ready), 64'd1);
        check_eq("wr_en_c65", 64'(bus.mem_wr_en), 64'd0);
        model_clear();
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        int nz;
        bus.upd_valid = 1'b0; bus.upd_index = '0; bus.upd_tag = '0;
        bus.upd_target = '0; bus.upd_is_branch = 1'b0; bus.upd_taken = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        model_clear();

        init_check();
        nz = 0;
        for (int i = 0; i < 64; i++) if (ram[i] != 32'd0) nz++;
        check_eq("ram_cleared", 64'(nz), 64'd0);

        // Allocate into empty table
        drive(1, 5, 3, 32'h1A0, 1, 1);
        idle(3);
        check_eq("alloc_idx5", 64'(ram[5]), 64'h0000_0000_0005_19A0);
        // Saturate up, then down, target kept
        repeat (3) drive(1, 5, 3, 32'h1A0, 1, 1);
        repeat (4) drive(1, 5, 3, 32'h0FF, 1, 0);
        idle(3);
        check_eq("sat_idx5", 64'(ram[5]), 64'h0000_0000_0001_19A0);
        // Back-to-back and one-gap hazards on idx 7
        drive(1, 7, 1, 32'h055, 1, 1);
        drive(1, 7, 1, 32'h055, 1, 1);
        idle(1);
        drive(1, 7, 1, 32'h055, 1, 0);
        idle(3);
        check_eq("fwd_idx7", 64'(ram[7]), 64'h0000_0000_0005_0855);
        // Tag replacement, then a non-branch that must not write
        drive(1, 5, 9, 32'h02B, 1, 0);
        drive(1, 5, 4, 32'h3FF, 0, 1);
        idle(3);
        check_eq("realloc_idx5", 64'(ram[5]), 64'h0000_0000_0003_482B);

        // Random traffic concentrated on few indices to stress forwarding
        for (int k = 0; k < 600; k++) begin
            int idx;
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 8, idx, $urandom_range(0, 3), $urandom_range(0, 2047),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);
        end
        idle(4);
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        nz = 0;
        for (int i = 0; i < 64; i++) begin
            if (ram[i] != (m_vld[i] ? mk_word(m_tgt[i], m_tag[i], 1, m_cnt[i]) : 32'd0)) nz++;
        end
        check_eq("table_final", 64'(nz), 64'd0);

        // Reset with two updates in flight: neither may write
        drive(1, 9, 2, 32'h100, 1, 1);
        @(negedge clk);
        mon_en = 1'b0;
        reset = 1'b1;
        bus.upd_valid = 1'b1; bus.upd_index = 6'd10; bus.upd_is_branch = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_flush_wr_en", 64'(bus.mem_wr_en), 64'd0);
        check_eq("rst_flush_ready", 64'(bus.upd_ready), 64'd0);
        @(posedge clk);
        #1;
        check_eq("rst_flush_wr_en2", 64'(bus.mem_wr_en), 64'd0);
        bus.upd_valid = 1'b0;
        init_check();

        // Post-restart: table must look empty again
        for (int k = 0; k < 100; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 2047), 1'b1, $urandom_range(0, 1) == 1);
        end
        idle(4);
        check_eq("drain2", 64'(exp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
